// File: rtl/mips_pkg.sv
// Shared MIPS definitions: word width, instruction-memory depth and loader states.
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int IMEM_DEPTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        CSUM
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles four bytes MSB-first into a 32-bit word; word_full strobes on the fourth byte.
module byte_packer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [1:0]        cnt;
    logic [WORD_W-9:0] shreg;

    // Only the three older bytes need storage; the newest is taken straight from byte_in.
    assign word      = {shreg, byte_in};
    assign word_full = shift_en && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt   <= 2'd0;
            shreg <= '0;
        end else if (shift_en) begin
            cnt   <= cnt + 2'd1;
            shreg <= word[WORD_W-9:0];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory, holding the CPU in reset during the load.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [WORD_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic              csum_err
`endif
);

    loader_state_t     state;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   n_clamp;
    logic [ADDR_W-1:0] widx;
    logic              accept;
    logic              last_word;
    logic              start_ok;
    logic [WORD_W-1:0] word;
    logic              word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_acc;
`endif

    assign n_clamp   = (word_count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : word_count;
    assign accept    = byte_valid && byte_ready && (state == RECV);
    assign last_word = ({1'b0, widx} == n_words - (ADDR_W+1)'(1));
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign cpu_hold  = busy;

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .shift_en  (accept),
        .byte_in   (byte_in),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            n_words    <= '0;
            widx       <= '0;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc   <= '0;
            csum_err   <= 1'b0;
`endif
        end else begin
            we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        done    <= 1'b0;
                        widx    <= '0;
                        n_words <= n_clamp;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_acc <= '0;
                        csum_err <= 1'b0;
`endif
                        if (n_clamp == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state      <= CSUM;
                            byte_ready <= 1'b1;
`else
                            state <= DONE;
                            done  <= 1'b1;
`endif
                        end else begin
                            state      <= RECV;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_acc <= csum_acc ^ byte_in;
`endif
                        if (word_full) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            we         <= 1'b1;
                            waddr      <= widx;
                            wdata      <= word;
                        end
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        busy <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state      <= CSUM;
                        byte_ready <= 1'b1;
`else
                        state <= DONE;
                        done  <= 1'b1;
`endif
                    end else begin
                        widx       <= widx + ADDR_W'(1);
                        state      <= RECV;
                        byte_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (byte_valid && byte_ready) begin
                        csum_err   <= (byte_in != csum_acc);
                        done       <= 1'b1;
                        byte_ready <= 1'b0;
                        state      <= DONE;
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads plus reset and checksum sequences.
module tb_imem_loader;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        cpu_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        csum_err;
`endif

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .csum_err   (csum_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [5:0]  wc;
        logic [31:0] base;
        int          gap;
        int          exp_n;
        logic [4:0]  exp_last;
    } vec_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   wr_cnt    = 0;
    bit   br_seen   = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Write-port monitor: every we pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_ready) br_seen = 1'b1;
            check("cpu_hold_eq_busy", cpu_hold, busy);
            if (we) begin
                wr_cnt++;
                check("ready_low_in_write", byte_ready, 0);
                if (sb.size() == 0) begin
                    check("unexpected_we", we, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("waddr", waddr, e.addr);
                    check("wdata", wdata, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [5:0] wc);
        word_count = wc;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t          = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 50) begin
            tick();
            t++;
        end
        if (!byte_ready) check("byte_ready_timeout", byte_ready, 1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, inout logic [7:0] cs);
        logic [7:0] bt;
        for (int b = 0; b < 4; b++) begin
            bt = 8'(w >> (24 - 8 * b));
            cs = cs ^ bt;
            send_byte(bt);
            if (b == 3) check("we_latency", we, 1);
            repeat (gap) tick();
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 200) begin
            tick();
            t++;
        end
        check("done", done, 1);
        check("busy_after_done", busy, 0);
        check("cpu_hold_after_done", cpu_hold, 0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0]  cs;
        logic [31:0] w;
        int          n;
        int          wr0;

        vecs[0] = '{wc: 6'd1,  base: 32'h0109F820, gap: 0, exp_n: 1,  exp_last: 5'd0};
        vecs[1] = '{wc: 6'd3,  base: 32'h12345678, gap: 1, exp_n: 3,  exp_last: 5'd2};
        vecs[2] = '{wc: 6'd0,  base: 32'h00000000, gap: 0, exp_n: 0,  exp_last: 5'd0};
        vecs[3] = '{wc: 6'd40, base: 32'hDEADBEEF, gap: 0, exp_n: 32, exp_last: 5'd31};
        vecs[4] = '{wc: 6'd5,  base: 32'hFFFFFFFF, gap: 2, exp_n: 5,  exp_last: 5'd4};
        vecs[5] = '{wc: 6'd32, base: 32'h00000000, gap: 0, exp_n: 32, exp_last: 5'd31};

        rst_n      = 1'b0;
        start      = 1'b0;
        word_count = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        repeat (2) tick();
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            n       = vecs[v].exp_n;
            wr0     = wr_cnt;
            cs      = 8'h00;
            br_seen = 1'b0;
            start_load(vecs[v].wc);
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (n == 0) check("zero_done_next_cycle", done, 1);
`endif
            for (int i = 0; i < n; i++) begin
                w = vecs[v].base ^ (i * 32'h01030507);
                sb.push_back('{addr: i[4:0], data: w});
                send_word(w, vecs[v].gap, cs);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(cs);
`endif
            wait_done();
            repeat (3) tick();
            check("done_held", done, 1);
            check("write_count", wr_cnt - wr0, n);
            check("sb_drained", sb.size(), 0);
            if (n > 0) check("last_waddr", waddr, vecs[v].exp_last);
`ifndef IMEM_LOADER_CHECKSUM_EN
            else check("zero_no_ready", br_seen, 0);
`endif
        end

        // Reset in the middle of the second word, after one complete write.
        cs = 8'h00;
        start_load(6'd2);
        sb.push_back('{addr: 5'd0, data: 32'hCAFEF00D});
        send_word(32'hCAFEF00D, 0, cs);
        start_load(6'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        check("busy_mid_load", busy, 1);
        rst_n = 1'b0;
        tick();
        check("midrst_we", we, 0);
        check("midrst_waddr", waddr, 0);
        check("midrst_wdata", wdata, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_byte_ready", byte_ready, 0);
        check("midrst_cpu_hold", cpu_hold, 0);
        rst_n = 1'b1;
        tick();
        wr0 = wr_cnt;
        cs  = 8'h00;
        start_load(6'd1);
        sb.push_back('{addr: 5'd0, data: 32'hA5A55A5A});
        send_word(32'hA5A55A5A, 0, cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cs);
`endif
        wait_done();
        check("post_rst_writes", wr_cnt - wr0, 1);
        check("post_rst_wdata", wdata, 32'hA5A55A5A);

`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            cs = 8'h00;
            start_load(6'd1);
            check("csum_err_cleared", csum_err, 0);
            sb.push_back('{addr: 5'd0, data: 32'h8C19000F});
            send_word(32'h8C19000F, 0, cs);
            send_byte(k == 0 ? 8'h9A : 8'h9B);
            wait_done();
            check("csum_err", csum_err, k);
        end
`endif

        repeat (2) tick();
        check("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Sequential writer for the word-indexed 32-bit instruction memory. The memory's read port stays combinational for the fetch path.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian (MIPS) instruction words.
- Writes each word to consecutive word addresses starting at 0, holding the CPU in reset while the load runs.
- Sits between the boot/debug byte source and the instruction-memory write port.

Parameters:
- DEPTH, 32, number of 32-bit words in instruction memory.
- ADDR_W, 5, word-address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin a load; ignored unless idle or done.
- word_count  in  ADDR_W+1  number of words to load; sampled on the accepted start.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction-memory write enable.
- waddr  out  ADDR_W  word address of the write.
- wdata  out  32  assembled instruction word.
- busy  out  1  load in progress.
- done  out  1  load complete; held until the next accepted start.
- cpu_hold  out  1  keeps the processor in reset; equals busy.

Behaviour:
- Reset (rst_n low at a clock edge) clears the following:
  - all outputs to 0;
  - state to IDLE;
  - byte counter, word counter and partial word to 0.
- Reset mid-load discards the partial word. Words already written stay in memory.
- States and transitions:
  - IDLE: on start, latch n = min(word_count, DEPTH). If n==0 go to DONE, otherwise go to RECV.
  - RECV: byte_ready=1. A byte is accepted when byte_valid && byte_ready.
    - Bytes shift in MSB-first: first byte goes to wdata[31:24], fourth byte to wdata[7:0].
    - On the 4th accepted byte, go to WRITE.
  - WRITE: lasts one cycle. we=1, waddr=word index, wdata=assembled word, byte_ready=0.
    - If index==n-1, go to DONE.
    - Otherwise increment index and go to RECV.
  - DONE: done=1, busy=0. On start, behave as in IDLE: clear done and re-latch word_count.
- busy=1 in RECV and WRITE only.
- start is ignored while busy.
- Latency:
  - we asserts exactly one cycle after the 4th byte is accepted.
  - byte_ready returns to 1 the cycle after WRITE.
  - Peak throughput is 4 bytes per 5 cycles.
- byte_valid gaps may be of any length. Partial-word state is held without timeout.
- we is 0 in every state except WRITE. waddr and wdata hold their last values otherwise.
- word_count > DEPTH is clamped to DEPTH. waddr never wraps.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit XOR of all payload bytes is accumulated.
  - After the final WRITE, a state CSUM accepts one extra byte with byte_ready=1.
  - A mismatch sets output csum_err=1; csum_err clears on the next start or on reset.
  - done asserts after the checksum byte is accepted.
  - With n==0 the expected checksum is 0x00.
- Disabled:
  - No CSUM state and no csum_err port.
  - done follows the last WRITE directly.

Decomposition:
- Shared package mips_pkg contains:
  - WORD_W=32 and IMEM_DEPTH=32;
  - the loader state enum (IDLE, RECV, WRITE, DONE, CSUM).
- One sub-module, byte_packer: 2-bit byte counter and 32-bit MSB-first shift register, with a word_full strobe and a clear input.

Test Plan:
- Single word: start, word_count=1, bytes 01 09 F8 20 -> one cycle later we=1, waddr=0, wdata=0x0109F820; next cycle done=1, busy=0, cpu_hold=0.
- Three words, byte_valid toggled every other cycle -> writes at addresses 0,1,2 in order with correct words; byte_ready=0 during each WRITE cycle.
- word_count=0 -> DONE one cycle after start, no we pulse, byte_ready never asserts.
- word_count=40 -> clamped to 32: last write has waddr=31, then done.
- Reset mid-word: rst_n low after 2 bytes of word 1 -> all outputs 0; a new load of 1 word writes waddr=0 from fresh bytes.
- Checksum enabled, bytes 8C 19 00 0F plus checksum 0x9A -> csum_err=0; with checksum 0x9B -> csum_err=1, done=1.
